// File: rtl/yuv_timing_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : yuv_timing_pattern_gen
// Description : Raster timing generator for a YUV444 stream
//               (vsync/hsync/de plus 8-bit Y/U/V) with selectable test
//               patterns in active video: grey, colour bars, Y ramp, checker.
//               Run request and pattern select take effect only at frame
//               boundaries, so a frame is never truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module yuv_timing_pattern_gen #(
  parameter int    H_ACTIVE    = 1280,
  parameter int    H_FP        = 110,
  parameter int    H_SYNC      = 40,
  parameter int    H_BP        = 220,
  parameter int    V_ACTIVE    = 720,
  parameter int    V_FP        = 5,
  parameter int    V_SYNC      = 5,
  parameter int    V_BP        = 20,
  parameter string HS_POLARITY = "POSITIVE",
  parameter string VS_POLARITY = "POSITIVE"
) (
  input  logic       i_pclk,
  input  logic       i_arst,
  input  logic       i_en,
  input  logic [1:0] i_pattern,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [7:0] o_y,
  output logic [7:0] o_u,
  output logic [7:0] o_v,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter widths are kept wide enough for the ramp (h_cnt[7:0]) and the
  // checker (bit 4 of both counters) to index real bits on small rasters.
  localparam int H_CW = $clog2(H_TOTAL);
  localparam int V_CW = $clog2(V_TOTAL);
  localparam int H_W  = (H_CW < 8) ? 8 : H_CW;
  localparam int V_W  = (V_CW < 5) ? 5 : V_CW;

  localparam int BAR_W  = H_ACTIVE / 8;
  localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [H_W-1:0]    C_H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    C_V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]    C_H_ACT     = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0]    C_V_ACT     = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0]    C_HS_START  = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]    C_HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0]    C_VS_START  = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]    C_VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BAR_CW-1:0] C_BAR_LAST  = BAR_CW'(BAR_W - 1);

  // Active level of each sync; the idle level is its complement.
  localparam logic C_HS_ON = (HS_POLARITY == "POSITIVE");
  localparam logic C_VS_ON = (VS_POLARITY == "POSITIVE");

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic [H_W-1:0]    h_cnt_q,   h_cnt_d;
  logic [V_W-1:0]    v_cnt_q,   v_cnt_d;
  logic [1:0]        pat_q,     pat_d;
  logic [BAR_CW-1:0] bar_px_q,  bar_px_d;
  logic [2:0]        bar_idx_q, bar_idx_d;
  logic              vsync_q,   vsync_d;
  logic              hsync_q,   hsync_d;
  logic              de_q,      de_d;
  logic [7:0]        y_q,       y_d;
  logic [7:0]        u_q,       u_d;
  logic [7:0]        v_q,       v_d;
  logic              fs_q,      fs_d;

  logic              frame_wrap;
  logic              de_w;
  logic              hs_w;
  logic              vs_w;
  logic [7:0]        bar_y, bar_u, bar_v;

  // Raster decode of the current counter values.
  always_comb begin
    frame_wrap = (h_cnt_q == C_H_LAST) && (v_cnt_q == C_V_LAST);
    de_w       = (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);
    hs_w       = (h_cnt_q >= C_HS_START) && (h_cnt_q < C_HS_END);
    vs_w       = (v_cnt_q >= C_VS_START) && (v_cnt_q < C_VS_END);
  end

  // Colour-bar lookup, left (white) to right (black).
  always_comb begin
    bar_y = 8'd16;
    bar_u = 8'd128;
    bar_v = 8'd128;
    case (bar_idx_q)
      3'd0: begin bar_y = 8'd235; bar_u = 8'd128; bar_v = 8'd128; end
      3'd1: begin bar_y = 8'd210; bar_u = 8'd16;  bar_v = 8'd146; end
      3'd2: begin bar_y = 8'd170; bar_u = 8'd166; bar_v = 8'd16;  end
      3'd3: begin bar_y = 8'd145; bar_u = 8'd54;  bar_v = 8'd34;  end
      3'd4: begin bar_y = 8'd106; bar_u = 8'd202; bar_v = 8'd222; end
      3'd5: begin bar_y = 8'd81;  bar_u = 8'd90;  bar_v = 8'd240; end
      3'd6: begin bar_y = 8'd41;  bar_u = 8'd240; bar_v = 8'd110; end
      default: begin bar_y = 8'd16; bar_u = 8'd128; bar_v = 8'd128; end
    endcase
  end

  // Next-state: run control, raster counters, pattern latch and bar tracking.
  always_comb begin
    state_d   = state_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pat_d     = pat_q;
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;

    case (state_q)
      IDLE: begin
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (i_en) begin
          state_d = RUN;
          pat_d   = i_pattern;
        end
      end
      RUN: begin
        if (h_cnt_q == C_H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == C_V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
        // Frame boundary is the only point where run/pattern are sampled.
        if (frame_wrap) begin
          if (i_en) pat_d   = i_pattern;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bar position follows h_cnt without a divider: a pixel counter within
    // the bar rolls the 3-bit index, and both restart with each line.
    if (h_cnt_d == '0) begin
      bar_px_d  = '0;
      bar_idx_d = '0;
    end else if (bar_px_q == C_BAR_LAST) begin
      bar_px_d  = '0;
      bar_idx_d = bar_idx_q + 3'd1;
    end else begin
      bar_px_d  = bar_px_q + 1'b1;
    end
  end

  // Output stage: one-cycle registered view of the current counter position.
  always_comb begin
    vsync_d = ~C_VS_ON;
    hsync_d = ~C_HS_ON;
    de_d    = 1'b0;
    y_d     = 8'd0;
    u_d     = 8'd0;
    v_d     = 8'd0;
    fs_d    = 1'b0;
    if (state_q == RUN) begin
      vsync_d = vs_w ? C_VS_ON : ~C_VS_ON;
      hsync_d = hs_w ? C_HS_ON : ~C_HS_ON;
      de_d    = de_w;
      fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
      y_d     = 8'd16;
      u_d     = 8'd128;
      v_d     = 8'd128;
      if (de_w) begin
        case (pat_q)
          2'd0: y_d = 8'd128;
          2'd1: begin y_d = bar_y; u_d = bar_u; v_d = bar_v; end
          2'd2: y_d = h_cnt_q[7:0];
          default: y_d = (h_cnt_q[4] ^ v_cnt_q[4]) ? 8'd235 : 8'd16;
        endcase
      end
    end
  end

  // All state and output registers, synchronous active-high reset.
  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      state_q   <= IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      pat_q     <= 2'd0;
      bar_px_q  <= '0;
      bar_idx_q <= 3'd0;
      vsync_q   <= ~C_VS_ON;
      hsync_q   <= ~C_HS_ON;
      de_q      <= 1'b0;
      y_q       <= 8'd0;
      u_q       <= 8'd0;
      v_q       <= 8'd0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      pat_q     <= pat_d;
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
      vsync_q   <= vsync_d;
      hsync_q   <= hsync_d;
      de_q      <= de_d;
      y_q       <= y_d;
      u_q       <= u_d;
      v_q       <= v_d;
      fs_q      <= fs_d;
    end
  end

  assign o_vsync       = vsync_q;
  assign o_hsync       = hsync_q;
  assign o_de          = de_q;
  assign o_y           = y_q;
  assign o_u           = u_q;
  assign o_v           = v_q;
  assign o_frame_start = fs_q;

endmodule
`default_nettype wire
